// File: rtl/nios2_ocimem_monitor.sv
// Debug monitor RAM and status block: executes JTAG host reads/writes into a
// single-port monitor RAM and shares that RAM with the CPU debugaccess slave.
module nios2_ocimem_monitor #(
   parameter int RAM_DEPTH = 256,
   parameter int ADDR_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_no_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic [ADDR_W:0]   address,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       writedata,
   input  logic [3:0]        byteenable,
   input  logic              debugaccess,
   output logic [31:0]       readdata,
   output logic              waitrequest,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error,
   output logic              monitor_go
);

   typedef enum logic [1:0] {S_IDLE, S_JRD, S_CRD} state_t;
   typedef enum logic [1:0] {J_NONE, J_ADDR, J_READ, J_WRITE} jop_t;

   state_t              state_q, state_d;
   jop_t                pend_op_q, pend_op_d;
   logic                pend_q, pend_d;
   logic [37:0]         pend_jdo_q, pend_jdo_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         mon_q, mon_d;
   logic [31:0]         readdata_q, readdata_d;
   logic                ready_q, ready_d;
   logic                error_q, error_d;
   logic                go_q, go_d;
   logic                rd_status_q, rd_status_d;

   jop_t                live_op, eff_op;
   logic [37:0]         eff_jdo;
   logic                cpu_wr_go, cpu_rd_go;
   logic                status_sel;
   logic [ADDR_W-1:0]   cpu_addr;
   logic [31:0]         rd_fresh;

   logic                ram_en;
   logic [3:0]          ram_we;
   logic [ADDR_W-1:0]   ram_addr;
   logic [31:0]         ram_wdata;
   logic [31:0]         ram_rdata_q;
   logic [31:0]         mem [RAM_DEPTH];

   logic                unused_ok;
   assign unused_ok = ^{eff_jdo[37:35], eff_jdo[2:0]};

   assign status_sel = address[ADDR_W];
   assign cpu_addr   = address[ADDR_W-1:0];

   always_comb begin
      live_op     = J_NONE;
      eff_op      = J_NONE;
      eff_jdo     = jdo;
      state_d     = state_q;
      pend_d      = pend_q;
      pend_op_d   = pend_op_q;
      pend_jdo_d  = pend_jdo_q;
      addr_d      = addr_q;
      mon_d       = mon_q;
      readdata_d  = readdata_q;
      ready_d     = ready_q;
      error_d     = error_q;
      go_d        = go_q;
      rd_status_d = rd_status_q;
      cpu_wr_go   = 1'b0;
      cpu_rd_go   = 1'b0;
      ram_en      = 1'b0;
      ram_we      = 4'h0;
      ram_addr    = addr_q;
      ram_wdata   = writedata;
      rd_fresh    = rd_status_q ? {29'b0, go_q, error_q, ready_q} : ram_rdata_q;

      if (take_action_ocimem_a)         live_op = J_ADDR;
      else if (take_no_action_ocimem_a) live_op = J_READ;
      else if (take_action_ocimem_b)    live_op = J_WRITE;

      // A strobe arriving while a read return is in flight is parked and
      // replayed on the first IDLE cycle, ahead of anything new.
      if (state_q == S_IDLE) begin
         if (pend_q) begin
            eff_op     = pend_op_q;
            eff_jdo    = pend_jdo_q;
            pend_d     = (live_op != J_NONE);
            pend_op_d  = live_op;
            pend_jdo_d = jdo;
         end else begin
            eff_op = live_op;
         end
      end else if (live_op != J_NONE) begin
         pend_d     = 1'b1;
         pend_op_d  = live_op;
         pend_jdo_d = jdo;
      end

      // Status writes never touch the RAM, so they may share a cycle with a
      // JTAG control strobe; the flag priority rules below resolve the overlap.
      if (state_q == S_IDLE) begin
         if (write)
            cpu_wr_go = status_sel ? (eff_op == J_NONE || eff_op == J_ADDR)
                                   : (eff_op == J_NONE);
         else if (read)
            cpu_rd_go = (eff_op == J_NONE);
      end

      case (eff_op)
         J_READ: begin
            ram_en   = 1'b1;
            ram_addr = addr_q;
            state_d  = S_JRD;
         end
         J_WRITE: begin
            ram_en    = 1'b1;
            ram_we    = 4'hF;
            ram_addr  = addr_q;
            ram_wdata = eff_jdo[34:3];
            mon_d     = eff_jdo[34:3];
            addr_d    = addr_q + ADDR_W'(1);
         end
         default: ;
      endcase

      if (cpu_wr_go && debugaccess) begin
         if (status_sel) begin
            if (writedata[0]) ready_d = 1'b1;
            if (writedata[1]) error_d = 1'b1;
            if (writedata[2]) go_d    = 1'b0;
         end else begin
            ram_en    = 1'b1;
            ram_we    = byteenable;
            ram_addr  = cpu_addr;
            ram_wdata = writedata;
         end
      end

      if (cpu_rd_go) begin
         ram_en      = !status_sel;
         ram_addr    = cpu_addr;
         rd_status_d = status_sel;
         state_d     = S_CRD;
      end

      // JTAG control is applied last so its clear and set win over the CPU.
      if (eff_op == J_ADDR) begin
         addr_d = eff_jdo[ADDR_W+9:10];
         if (eff_jdo[25]) begin
            ready_d = 1'b0;
            error_d = 1'b0;
         end
         if (eff_jdo[26]) go_d = 1'b1;
      end

      case (state_q)
         S_JRD: begin
            mon_d   = ram_rdata_q;
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_IDLE;
         end
         S_CRD: begin
            readdata_d = rd_fresh;
            state_d    = S_IDLE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         pend_q      <= 1'b0;
         pend_op_q   <= J_NONE;
         pend_jdo_q  <= '0;
         addr_q      <= '0;
         mon_q       <= '0;
         readdata_q  <= '0;
         ready_q     <= 1'b0;
         error_q     <= 1'b0;
         go_q        <= 1'b0;
         rd_status_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         pend_op_q   <= pend_op_d;
         pend_jdo_q  <= pend_jdo_d;
         addr_q      <= addr_d;
         mon_q       <= mon_d;
         readdata_q  <= readdata_d;
         ready_q     <= ready_d;
         error_q     <= error_d;
         go_q        <= go_d;
         rd_status_q <= rd_status_d;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_en) begin
         for (int i = 0; i < 4; i++)
            if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
         ram_rdata_q <= mem[ram_addr];
      end
   end

   // Read data is presented in the completion cycle and then held.
   assign readdata      = (state_q == S_CRD) ? rd_fresh : readdata_q;
   assign waitrequest   = reset | ~(cpu_wr_go | (state_q == S_CRD));
   assign MonDReg       = mon_q;
   assign monitor_ready = ready_q;
   assign monitor_error = error_q;
   assign monitor_go    = go_q;

endmodule

// File: tb/tb_nios2_ocimem_monitor.sv
// Directed bench for nios2_ocimem_monitor with a queue of expected read results.
module tb_nios2_ocimem_monitor;

   logic        clk;
   logic        reset;
   logic [37:0] jdo;
   logic        take_action_ocimem_a;
   logic        take_no_action_ocimem_a;
   logic        take_action_ocimem_b;
   logic [8:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic        debugaccess;
   logic [31:0] readdata;
   logic        waitrequest;
   logic [31:0] MonDReg;
   logic        monitor_ready;
   logic        monitor_error;
   logic        monitor_go;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] model [256];
   logic [31:0] exp_q [$];
   logic [7:0]  addr_m;
   int          stalls;

   nios2_ocimem_monitor #(.RAM_DEPTH(256), .ADDR_W(8)) dut (
      .clk(clk), .reset(reset), .jdo(jdo),
      .take_action_ocimem_a(take_action_ocimem_a),
      .take_no_action_ocimem_a(take_no_action_ocimem_a),
      .take_action_ocimem_b(take_action_ocimem_b),
      .address(address), .read(read), .write(write), .writedata(writedata),
      .byteenable(byteenable), .debugaccess(debugaccess),
      .readdata(readdata), .waitrequest(waitrequest), .MonDReg(MonDReg),
      .monitor_ready(monitor_ready), .monitor_error(monitor_error),
      .monitor_go(monitor_go)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic jtag_a(input logic [7:0] a, input logic clr, input logic go);
      jdo = '0;
      jdo[17:10] = a;
      jdo[25] = clr;
      jdo[26] = go;
      take_action_ocimem_a = 1'b1;
      tick();
      take_action_ocimem_a = 1'b0;
      addr_m = a;
   endtask

   task automatic jtag_wr(input logic [31:0] d);
      jdo = '0;
      jdo[34:3] = d;
      take_action_ocimem_b = 1'b1;
      tick();
      take_action_ocimem_b = 1'b0;
      model[addr_m] = d;
      addr_m++;
      check("jtag_wr_mondreg", MonDReg, d);
   endtask

   task automatic jtag_rd;
      take_no_action_ocimem_a = 1'b1;
      exp_q.push_back(model[addr_m]);
      addr_m++;
      tick();
      take_no_action_ocimem_a = 1'b0;
      tick();
      check("jtag_rd_mondreg", MonDReg, exp_q.pop_front());
   endtask

   task automatic cpu_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be,
                            input logic dbg);
      logic done;
      address = a; writedata = d; byteenable = be; debugaccess = dbg; write = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (!waitrequest) done = 1'b1;
         tick();
      end
      write = 1'b0;
      debugaccess = 1'b0;
      check("cpu_wr_done", 32'(done), 32'd1);
      if (dbg && !a[8])
         for (int b = 0; b < 4; b++)
            if (be[b]) model[a[7:0]][8*b +: 8] = d[8*b +: 8];
   endtask

   task automatic finish_read(output int n_stall);
      logic        done;
      logic [31:0] got;
      done = 1'b0;
      got = '0;
      n_stall = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (!waitrequest) begin
            done = 1'b1;
            got = readdata;
         end else begin
            n_stall++;
         end
         tick();
      end
      read = 1'b0;
      #1;
      check("cpu_rd_done", 32'(done), 32'd1);
      check("cpu_rd_data", got, exp_q.pop_front());
      check("cpu_wait_after_rd", 32'(waitrequest), 32'd1);
   endtask

   task automatic cpu_read(input logic [8:0] a, input logic [31:0] exp);
      address = a;
      read = 1'b1;
      exp_q.push_back(exp);
      finish_read(stalls);
      check("cpu_rd_latency", 32'(stalls), 32'd1);
   endtask

   initial begin
      reset = 1'b1;
      jdo = '0;
      take_action_ocimem_a = 1'b0;
      take_no_action_ocimem_a = 1'b0;
      take_action_ocimem_b = 1'b0;
      address = '0; read = 1'b0; write = 1'b0; writedata = '0;
      byteenable = '0; debugaccess = 1'b0;
      addr_m = '0;
      for (int i = 0; i < 256; i++) model[i] = 32'h0;

      repeat (3) tick();
      check("rst_readdata", readdata, 32'h0);
      check("rst_mondreg", MonDReg, 32'h0);
      check("rst_flags", {29'b0, monitor_go, monitor_error, monitor_ready}, 32'h0);
      check("rst_wait", 32'(waitrequest), 32'd1);
      reset = 1'b0;
      tick();

      // Zero the words the directed steps read back, since RAM has no reset.
      cpu_write(9'h000, 32'h0, 4'hF, 1'b1);
      cpu_write(9'h011, 32'h0, 4'hF, 1'b1);

      // JTAG write then read-back
      jtag_a(8'h10, 1'b0, 1'b0);
      jtag_wr(32'hDEADBEEF);
      jtag_a(8'h10, 1'b0, 1'b0);
      jtag_rd();
      check("addr_after_rd", 32'(dut.addr_q), 32'h11);
      jtag_rd();
      check("addr_after_rd2", 32'(dut.addr_q), 32'h12);

      // Address wrap
      jtag_a(8'hFF, 1'b0, 1'b0);
      jtag_wr(32'h1);
      jtag_wr(32'h2);
      check("addr_wrapped", 32'(dut.addr_q), 32'h1);
      cpu_read(9'h0FF, 32'h1);
      cpu_read(9'h000, 32'h2);

      // Arbitration: CPU read held while a JTAG write hits the same word
      jtag_a(8'h10, 1'b0, 1'b0);
      jdo = '0;
      jdo[34:3] = 32'h12345678;
      take_action_ocimem_b = 1'b1;
      address = 9'h010;
      read = 1'b1;
      model[addr_m] = 32'h12345678;
      addr_m++;
      exp_q.push_back(32'h12345678);
      @(negedge clk);
      check("arb_wait_jtag_cycle", 32'(waitrequest), 32'd1);
      tick();
      take_action_ocimem_b = 1'b0;
      finish_read(stalls);
      check("arb_extra_stall", 32'(stalls >= 1), 32'd1);

      // Byte enables and debugaccess qualification
      cpu_write(9'h000, 32'h0, 4'hF, 1'b1);
      cpu_write(9'h000, 32'hAABBCCDD, 4'b0101, 1'b1);
      cpu_read(9'h000, 32'h00BB00DD);
      cpu_write(9'h000, 32'hAABBCCDD, 4'hF, 1'b0);
      cpu_read(9'h000, 32'h00BB00DD);

      // Status register
      jtag_a(8'h00, 1'b0, 1'b1);
      check("go_set", 32'(monitor_go), 32'd1);
      cpu_write(9'h100, 32'h5, 4'hF, 1'b1);
      check("status_after_5", {29'b0, monitor_go, monitor_error, monitor_ready}, 32'h1);
      cpu_read(9'h100, 32'h1);
      cpu_write(9'h100, 32'h2, 4'hF, 1'b0);
      check("status_dbg0", {29'b0, monitor_go, monitor_error, monitor_ready}, 32'h1);

      jdo = '0;
      jdo[25] = 1'b1;
      take_action_ocimem_a = 1'b1;
      address = 9'h100; writedata = 32'h2; byteenable = 4'hF; debugaccess = 1'b1; write = 1'b1;
      @(negedge clk);
      check("status_wr_with_jtag_wait", 32'(waitrequest), 32'd0);
      tick();
      take_action_ocimem_a = 1'b0; write = 1'b0; debugaccess = 1'b0;
      check("clear_wins", {29'b0, monitor_go, monitor_error, monitor_ready}, 32'h0);

      jdo = '0;
      jdo[26] = 1'b1;
      take_action_ocimem_a = 1'b1;
      address = 9'h100; writedata = 32'h4; debugaccess = 1'b1; write = 1'b1;
      tick();
      take_action_ocimem_a = 1'b0; write = 1'b0; debugaccess = 1'b0;
      check("go_set_wins", 32'(monitor_go), 32'd1);

      // Reset in the middle of a CPU read return
      address = 9'h010;
      read = 1'b1;
      tick();
      check("mid_crd_wait", 32'(waitrequest), 32'd0);
      reset = 1'b1;
      read = 1'b0;
      #1;
      check("rst_crd_wait", 32'(waitrequest), 32'd1);
      check("rst_crd_readdata", readdata, 32'h0);
      check("rst_crd_mondreg", MonDReg, 32'h0);
      check("rst_crd_go", 32'(monitor_go), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      check("state_idle", 32'(dut.state_q), 32'd0);
      cpu_read(9'h000, 32'h00BB00DD);

      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/nios2_ocimem_monitor.md
Name: nios2_ocimem_monitor

Overview:
- Debug monitor RAM plus status block, directly downstream of the JTAG debug-module sysclk stage.
- Consumes `jdo` and the ocimem take-action strobes, and executes host reads/writes into a single-port monitor RAM.
- Returns `MonDReg`, `monitor_ready` and `monitor_error` upstream for JTAG capture.
- Arbitrates the same RAM against the CPU's debugaccess Avalon slave port.

Parameters:
- RAM_DEPTH, 256, monitor RAM words (32-bit); power of two.
- ADDR_W, 8, log2(RAM_DEPTH).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- jdo  in  38  JTAG data from sysclk stage
- take_action_ocimem_a  in  1  one-cycle strobe: set address / control
- take_no_action_ocimem_a  in  1  one-cycle strobe: read at address, post-increment
- take_action_ocimem_b  in  1  one-cycle strobe: write at address, post-increment
- address  in  ADDR_W+1  CPU word address; MSB=1 selects status register
- read  in  1  CPU read request
- write  in  1  CPU write request
- writedata  in  32  CPU write data
- byteenable  in  4  CPU byte lanes
- debugaccess  in  1  CPU access qualifier; writes ignored when 0
- readdata  out  32  CPU read data
- waitrequest  out  1  CPU stall
- MonDReg  out  32  monitor data register, to JTAG stage
- monitor_ready  out  1  CPU signalled command complete
- monitor_error  out  1  CPU signalled command error
- monitor_go  out  1  host requested monitor run

Behaviour:
- Reset values (immediate on reset=1): MonDReg=0, readdata=0, addr_reg=0, monitor_ready/error/go=0, state=IDLE. Any pending read is discarded and `waitrequest`=1.
- State machine: IDLE, JRD (JTAG read data return), CRD (CPU read data return).
- JTAG strobes are mutually exclusive. JTAG accesses have priority over CPU accesses.
- take_action_ocimem_a:
  - addr_reg <= jdo[ADDR_W+9:10].
  - jdo[25]=1: clear monitor_ready and monitor_error.
  - jdo[26]=1: set monitor_go.
  - No RAM access.
- take_no_action_ocimem_a:
  - RAM read at addr_reg issued in the strobe cycle; state -> JRD.
  - In JRD: MonDReg <= RAM data; addr_reg <= addr_reg+1; state -> IDLE.
  - Latency: MonDReg is valid 2 cycles after the strobe.
- take_action_ocimem_b:
  - RAM[addr_reg] <= jdo[34:3] (all bytes); MonDReg <= jdo[34:3]; addr_reg+1 in the same cycle.
- Address wrap: addr_reg wraps modulo RAM_DEPTH (RAM_DEPTH-1 -> 0).
- CPU grant: a CPU access is granted only in IDLE with no JTAG strobe that cycle. Otherwise `waitrequest`=1 and the request must be held.
- waitrequest = 1 in every cycle except an access's completion cycle.
- CPU write:
  - Completes in the grant cycle (waitrequest=0).
  - RAM: byte lanes per byteenable, only when debugaccess=1.
  - Status register (address MSB=1): writedata[0]=1 sets ready, [1]=1 sets error, [2]=1 clears go.
  - Writes with debugaccess=0 complete but have no effect.
- CPU read:
  - Grant cycle issues the read; state -> CRD.
  - In CRD: readdata <= RAM data, or {29'b0, go, error, ready} for the status register; waitrequest=0; state -> IDLE.
  - Minimum read latency is 2 cycles.
- Simultaneous events:
  - A JTAG strobe during CRD or JRD is illegal upstream; if it occurs, it is captured and the current return completes first.
  - A JTAG clear (jdo[25]) in the same cycle as a CPU status set: the clear wins.
  - A CPU clear of go in the same cycle as a JTAG set of go: the set wins.
- RAM is inferred single-port, with a synchronous read and one access per cycle.

Test Plan:
- Post-reset values: assert reset mid-CRD -> waitrequest=1, readdata=0, MonDReg=0, and state IDLE after release. The next CPU read at address 0 completes normally.
- JTAG write then read-back:
  - take_action_ocimem_a with jdo[17:10]=0x10.
  - take_action_ocimem_b with jdo[34:3]=0xDEADBEEF.
  - take_action_ocimem_a with jdo[17:10]=0x10 again, then take_no_action_ocimem_a.
  - Required: MonDReg=0xDEADBEEF 2 cycles after the read strobe; addr_reg=0x11.
- Address wrap: set address 0xFF, then two take_action_ocimem_b writes of 0x1 and 0x2 -> RAM[0xFF]=0x1 and RAM[0x00]=0x2.
- Arbitration: CPU read of 0x10 held in the same cycle as take_action_ocimem_b -> CPU stalled ≥1 extra cycle; readdata shows the newly written value, waitrequest=0 for exactly one cycle.
- Byte enables / debugaccess:
  - CPU write 0xAABBCCDD, byteenable=0b0101, debugaccess=1, over 0x0 -> word reads 0x00BB00DD.
  - Same write with debugaccess=0 -> no change.
- Status register:
  - JTAG jdo[26]=1 -> monitor_go=1.
  - CPU writes status 0x5 -> ready=1, go=0.
  - JTAG jdo[25]=1 together with a CPU write of 0x2 -> ready=0, error=0.
